mmio_ctrl: RTL and testbench

MMIO_CTRL -- requirements
Module: mmio_ctrl

---
 rtl/io_pkg.sv | 15 +
 rtl/btn_debounce.sv | 50 +++++
 rtl/mmio_ctrl.sv | 90 +++++++++
 tb/tb_mmio_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared MMIO address map and controller state encoding
package io_pkg;

  localparam logic [31:0] DEF_SEG_ADDR = 32'hFFFF_FFF0;
  localparam logic [31:0] DEF_LED_ADDR = 32'hFFFF_FFF4;
  localparam logic [31:0] DEF_SWW_ADDR = 32'hFFFF_FFF8;
  localparam logic [31:0] DEF_SWI_ADDR = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RESP      = 2'd1,
    WAIT_CONF = 2'd2
  } ioState_t;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - switch/button synchronizers, button debounce and press edge detect
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int SW_W            = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btnRaw,
  input  logic [SW_W-1:0] swRaw,
  output logic [SW_W-1:0] swSync,
  output logic            press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic            btnMeta, btnSync;
  logic [SW_W-1:0] swMeta;
  logic [CW-1:0]   cnt;
  logic            btnStable, btnStableQ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btnMeta    <= 1'b0;
      btnSync    <= 1'b0;
      swMeta     <= '0;
      swSync     <= '0;
      cnt        <= '0;
      btnStable  <= 1'b0;
      btnStableQ <= 1'b0;
    end else begin
      btnMeta    <= btnRaw;
      btnSync    <= btnMeta;
      swMeta     <= swRaw;
      swSync     <= swMeta;
      btnStableQ <= btnStable;
      // any cycle agreeing with the accepted level restarts the stability count
      if (btnSync == btnStable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        btnStable <= btnSync;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = btnStable & ~btnStableQ;

endmodule

// File: rtl/mmio_ctrl.sv
// rtl/mmio_ctrl.sv - CPU MMIO slave for seven-segment, LEDs and switches with confirm-press read
module mmio_ctrl
  import io_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 20,
  parameter logic [31:0] SEG_ADDR        = DEF_SEG_ADDR,
  parameter logic [31:0] LED_ADDR        = DEF_LED_ADDR,
  parameter logic [31:0] SWW_ADDR        = DEF_SWW_ADDR,
  parameter logic [31:0] SWI_ADDR        = DEF_SWI_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  input  logic [15:0] sw_in,
  input  logic        confirm_btn,
  output logic [31:0] seg_data,
  output logic [15:0] led_data,
  output logic        waiting
);

  ioState_t    state, nextState;
  logic [15:0] swSync;
  logic        press;
  logic        errQ;
  logic        accept;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SW_W           (16)
  ) uDebounce (
    .clk   (clk),
    .rst   (rst),
    .btnRaw(confirm_btn),
    .swRaw (sw_in),
    .swSync(swSync),
    .press (press)
  );

  assign accept = (state == IDLE) && req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:      if (req) nextState = (!we && addr == SWW_ADDR) ? WAIT_CONF : RESP;
      RESP:      nextState = IDLE;
      WAIT_CONF: if (press) nextState = RESP;
      default:   nextState = IDLE;
    endcase
  end

  assign ack     = (state == RESP);
  assign err     = ack & errQ;
  assign waiting = (state == WAIT_CONF);

  // register side effects happen on the accept edge; addr/we/wdata are not looked at afterwards
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata    <= '0;
      seg_data <= '0;
      led_data <= '0;
      errQ     <= 1'b0;
    end else if (accept) begin
      errQ <= 1'b0;
      case (addr)
        SEG_ADDR: if (we) seg_data <= wdata; else rdata <= seg_data;
        LED_ADDR: if (we) led_data <= wdata[15:0]; else rdata <= {16'h0, led_data};
        SWI_ADDR: if (!we) rdata <= {16'h0, swSync};
        SWW_ADDR: ;
        default: begin
          errQ  <= 1'b1;
          rdata <= '0;
        end
      endcase
    end else if (state == WAIT_CONF && press) begin
      rdata <= {16'h0, swSync};
    end
  end

endmodule

// File: tb/tb_mmio_ctrl.sv
// tb/tb_mmio_ctrl.sv - scoreboard bench for mmio_ctrl
module tb_mmio_ctrl;

  localparam logic [31:0] A_SEG = 32'hFFFF_FFF0;
  localparam logic [31:0] A_LED = 32'hFFFF_FFF4;
  localparam logic [31:0] A_SWW = 32'hFFFF_FFF8;
  localparam logic [31:0] A_SWI = 32'hFFFF_FFFC;

  typedef struct {
    logic [31:0] rd;
    logic        e;
    logic        chkRd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, req, we, btn;
  logic [31:0] addr, wdata;
  logic [15:0] sw;
  logic        ack, err, waiting;
  logic [31:0] rdata, seg_data;
  logic [15:0] led_data;

  exp_t sb[$];
  exp_t monE;
  int   checks = 0;
  int   errors = 0;
  int   ackCount = 0;
  int   n, acks0;

  always #5 clk = ~clk;

  mmio_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .err(err), .sw_in(sw), .confirm_btn(btn),
    .seg_data(seg_data), .led_data(led_data), .waiting(waiting)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] er, input logic ee, input logic cr);
    exp_t x;
    x.rd = er; x.e = ee; x.chkRd = cr;
    sb.push_back(x);
    @(posedge clk) #1;
    req = 1'b1; we = w; addr = a; wdata = d;
  endtask

  // n counts samples without ack; a 1-cycle access shows one idle sample before the accept edge
  task automatic waitAck(input int maxCyc, output int cnt);
    cnt = 0;
    forever begin
      @(negedge clk);
      if (ack) break;
      cnt++;
      if (cnt >= maxCyc) break;
    end
    check("ack_seen", {31'h0, ack}, 32'h1);
    if (!ack && sb.size() > 0) void'(sb.pop_front());
  endtask

  task automatic endReq();
    @(posedge clk) #1;
    req = 1'b0;
  endtask

  task automatic cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst && ack) begin
      ackCount++;
      if (sb.size() == 0) begin
        check("unexp_ack", {31'h0, ack}, 32'h0);
      end else begin
        monE = sb.pop_front();
        if (monE.chkRd) check("rdata", rdata, monE.rd);
        check("err", {31'h0, err}, {31'h0, monE.e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; sw = '0; btn = 1'b0;
    cycles(3);
    check("rst_ack", {31'h0, ack}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_waiting", {31'h0, waiting}, 32'h0);
    check("rst_seg", seg_data, 32'h0);
    check("rst_led", {16'h0, led_data}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    rst = 1'b1;
    cycles(2);

    issue(1'b1, A_SEG, 32'h1234_ABCD, 32'h0, 1'b0, 1'b0);
    waitAck(20, n); check("lat_seg_wr", n, 1);
    check("seg_after_wr", seg_data, 32'h1234_ABCD);
    endReq();

    issue(1'b1, A_LED, 32'hFFFF_5A3C, 32'h0, 1'b0, 1'b0);
    waitAck(20, n); check("lat_led_wr", n, 1);
    check("led_after_wr", {16'h0, led_data}, 32'h0000_5A3C);
    endReq();

    sw = 16'hA5A5;
    cycles(4);
    issue(1'b0, A_SWI, 32'h0, 32'h0000_A5A5, 1'b0, 1'b1);
    waitAck(20, n); check("lat_swi_rd", n, 1);

    issue(1'b0, A_SEG, 32'h0, 32'h1234_ABCD, 1'b0, 1'b1);
    waitAck(20, n); check("lat_b2b_1", n, 1);
    issue(1'b0, A_LED, 32'h0, 32'h0000_5A3C, 1'b0, 1'b1);
    waitAck(20, n); check("lat_b2b_2", n, 1);
    issue(1'b1, A_SWI, 32'h7777_7777, 32'h0, 1'b0, 1'b0);
    waitAck(20, n);
    endReq();
    check("seg_after_swi_wr", seg_data, 32'h1234_ABCD);
    check("led_after_swi_wr", {16'h0, led_data}, 32'h0000_5A3C);

    issue(1'b0, 32'hFFFF_0000, 32'h0, 32'h0, 1'b1, 1'b1);
    waitAck(20, n); check("lat_unmapped_rd", n, 1);
    issue(1'b1, 32'hFFFF_0004, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b1);
    waitAck(20, n);
    endReq();
    check("seg_after_unmapped", seg_data, 32'h1234_ABCD);
    check("led_after_unmapped", {16'h0, led_data}, 32'h0000_5A3C);

    // waiting read: bounce must not complete it, bus changes while waiting are ignored
    sw = 16'h00FF;
    cycles(4);
    issue(1'b0, A_SWW, 32'h0, 32'h0000_00FF, 1'b0, 1'b1);
    acks0 = ackCount;
    cycles(6);
    check("waiting_set", {31'h0, waiting}, 32'h1);
    addr = A_SEG; we = 1'b1; wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      btn = ~btn;
      cycles(1);
    end
    btn = 1'b0;
    cycles(10);
    check("no_ack_bounce", ackCount, acks0);
    check("waiting_bounce", {31'h0, waiting}, 32'h1);
    btn = 1'b1;
    waitAck(40, n);
    endReq();
    btn = 1'b0;
    cycles(15);
    check("one_ack_press", ackCount, acks0 + 1);
    check("waiting_clear", {31'h0, waiting}, 32'h0);
    check("seg_ignored_wait", seg_data, 32'h1234_ABCD);

    // a press in IDLE is dropped
    acks0 = ackCount;
    btn = 1'b1; cycles(12);
    btn = 1'b0; cycles(12);
    check("idle_press_no_ack", ackCount, acks0);
    sw = 16'h1234;
    cycles(4);
    issue(1'b0, A_SWW, 32'h0, 32'h0000_1234, 1'b0, 1'b1);
    cycles(20);
    check("no_queued_press", ackCount, acks0);
    check("waiting_2", {31'h0, waiting}, 32'h1);
    btn = 1'b1;
    waitAck(40, n);
    endReq();
    btn = 1'b0;
    cycles(15);
    check("second_press_ack", ackCount, acks0 + 1);

    // reset aborts a pending waiting read
    issue(1'b0, A_SWW, 32'h0, 32'h0000_1234, 1'b0, 1'b1);
    cycles(5);
    check("waiting_3", {31'h0, waiting}, 32'h1);
    acks0 = ackCount;
    @(negedge clk) #2;
    rst = 1'b0;
    #1;
    check("rstw_waiting", {31'h0, waiting}, 32'h0);
    check("rstw_seg", seg_data, 32'h0);
    check("rstw_led", {16'h0, led_data}, 32'h0);
    check("rstw_ack", {31'h0, ack}, 32'h0);
    if (sb.size() > 0) void'(sb.pop_back());
    req = 1'b0;
    cycles(3);
    rst = 1'b1;
    btn = 1'b1; cycles(12);
    btn = 1'b0; cycles(12);
    check("rstw_no_ack", ackCount, acks0);
    check("rstw_idle", {31'h0, waiting}, 32'h0);
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
